// File: rtl/out_channel_arbiter.sv
// Round-robin arbiter that funnels NReq requesters into one shared FIFO out channel.
// Grants are registered one-hot pulses; a granted requester is masked for one cycle.
module out_channel_arbiter #(
   parameter int MemoryElementWidth = 12,
   parameter int NReq               = 4,
   parameter int NOut               = 8
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic [NReq-1:0]                    req,
   input  logic [NReq*MemoryElementWidth-1:0] reqData,
   output logic [NReq-1:0]                    grant,
   output logic                               outValid,
   output logic [MemoryElementWidth-1:0]      outData,
   input  logic                               outReady,
   output logic [$clog2(NOut):0]              count,
   output logic                               overflowSeen
);

   localparam int PtrW = $clog2(NOut);
   localparam int CntW = PtrW + 1;
   localparam int LgW  = $clog2(NReq);

   logic [MemoryElementWidth-1:0] req_word [NReq];
   logic [MemoryElementWidth-1:0] mem_q    [NOut];

   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic [LgW-1:0]  last_grant_q, last_grant_d;
   logic [NReq-1:0] grant_q, grant_d;
   logic            overflow_q, overflow_d;

   logic            full, pop, push, found;
   logic [NReq-1:0] req_eff;
   logic [LgW-1:0]  winner, idx;

   genvar gi;
   generate
      for (gi = 0; gi < NReq; gi++) begin : g_slice
         assign req_word[gi] = reqData[gi*MemoryElementWidth +: MemoryElementWidth];
      end
   endgenerate

   always_comb begin
      full    = (count_q == CntW'(NOut));
      pop     = (count_q != '0) && outReady;
      // The requester granted last cycle still has its req up; skip it once.
      req_eff = req & ~grant_q;
      found   = 1'b0;
      winner  = last_grant_q;
      idx     = '0;
      for (int i = 1; i <= NReq; i++) begin
         idx = LgW'((int'(last_grant_q) + i) % NReq);
         if (!found && req_eff[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
      push = found && (!full || pop);

      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      last_grant_d = last_grant_q;
      grant_d      = '0;
      if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push) begin
         wr_ptr_d     = wr_ptr_q + PtrW'(1);
         last_grant_d = winner;
         grant_d      = {{(NReq-1){1'b0}}, 1'b1} << winner;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase

      overflow_d = overflow_q | (full && !pop && (|req));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         last_grant_q <= LgW'(NReq - 1);
         grant_q      <= '0;
         overflow_q   <= 1'b0;
      end else begin
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         overflow_q   <= overflow_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push && !reset) mem_q[wr_ptr_q] <= req_word[winner];
   end

   assign grant        = grant_q;
   assign outValid     = (count_q != '0);
   assign outData      = mem_q[rd_ptr_q];
   assign count        = count_q;
   assign overflowSeen = overflow_q;

endmodule

// File: tb/tb_out_channel_arbiter.sv
// Self-checking bench for out_channel_arbiter: constant vector table, directed corner
// sequences and random traffic compared against a queue-based reference model.
module tb_out_channel_arbiter;
   localparam int W    = 12;
   localparam int NREQ = 4;
   localparam int NOUT = 8;

   logic              clock = 1'b0;
   logic              reset;
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] reqData;
   logic [NREQ-1:0]   grant;
   logic              outValid;
   logic [W-1:0]      outData;
   logic              outReady;
   logic [3:0]        count;
   logic              overflowSeen;

   out_channel_arbiter #(.MemoryElementWidth(W), .NReq(NREQ), .NOut(NOUT)) dut (
      .clock(clock), .reset(reset), .req(req), .reqData(reqData), .grant(grant),
      .outValid(outValid), .outData(outData), .outReady(outReady), .count(count),
      .overflowSeen(overflowSeen)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   int              mq[$];
   int              mlast;
   logic [NREQ-1:0] mgrant;
   bit              movf;
   int              popped[$];

   typedef struct {
      logic       rst;
      logic [3:0] r;
      logic       rdy;
      int         base;
      logic [3:0] eg;
      int         ec;
      logic       ev;
      int         ed;
   } vec_t;
   vec_t tbl[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [NREQ*W-1:0] pack(input int base);
      logic [NREQ*W-1:0] v;
      for (int k = 0; k < NREQ; k++) v[k*W +: W] = W'(base + 100*k);
      return v;
   endfunction

   task automatic model_reset();
      mq.delete();
      mlast  = NREQ - 1;
      mgrant = '0;
      movf   = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1; req = '0; outReady = 1'b0; reqData = '0;
      @(posedge clock); #1;
      reset = 1'b0;
      model_reset();
      $display("reset applied");
   endtask

   // One cycle against the reference model: check present outputs, then advance.
   task automatic cyc(input logic [NREQ-1:0] r, input logic rdy, input logic [NREQ*W-1:0] d);
      bit p_pop, p_push;
      int w;
      logic [NREQ-1:0] eff;
      req = r; outReady = rdy; reqData = d;
      #1;
      chk("valid", 32'(outValid), 32'(mq.size() != 0));
      chk("count", 32'(count), 32'(mq.size()));
      chk("grant", 32'(grant), 32'(mgrant));
      chk("overflow", 32'(overflowSeen), 32'(movf));
      if (mq.size() != 0) chk("data", 32'(outData), 32'(mq[0]));
      if (outValid && outReady) popped.push_back(int'(outData));
      p_pop  = (mq.size() != 0) && rdy;
      eff    = r & ~mgrant;
      p_push = (eff != 0) && ((mq.size() < NOUT) || p_pop);
      if (mq.size() == NOUT && !p_pop && r != 0) movf = 1'b1;
      if (p_pop) void'(mq.pop_front());
      mgrant = '0;
      w = 0;
      if (p_push) begin
         for (int k = 1; k <= NREQ; k++) begin
            w = (mlast + k) % NREQ;
            if (eff[w]) break;
         end
         mq.push_back(int'(d[w*W +: W]));
         mlast     = w;
         mgrant[w] = 1'b1;
      end
      $display("cyc req=%b rdy=%0d push=%0d win=%0d pop=%0d occ=%0d", r, rdy, p_push, w, p_pop, mq.size());
      @(posedge clock); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int g1, k, exp_next;
      logic [63:0] rnd;
      logic [NREQ-1:0] rr;
      logic rdy;

      // Single requester 3,33,2, then reset, then fairness with all four requesting.
      tbl[0]  = '{1'b0, 4'b0001, 1'b1, 3,  4'b0001, 1, 1'b1, 3};
      tbl[1]  = '{1'b0, 4'b0001, 1'b1, 33, 4'b0000, 0, 1'b0, 0};
      tbl[2]  = '{1'b0, 4'b0001, 1'b1, 33, 4'b0001, 1, 1'b1, 33};
      tbl[3]  = '{1'b0, 4'b0001, 1'b1, 2,  4'b0000, 0, 1'b0, 0};
      tbl[4]  = '{1'b0, 4'b0001, 1'b1, 2,  4'b0001, 1, 1'b1, 2};
      tbl[5]  = '{1'b0, 4'b0000, 1'b1, 0,  4'b0000, 0, 1'b0, 0};
      tbl[6]  = '{1'b1, 4'b1111, 1'b1, 0,  4'b0000, 0, 1'b0, 0};
      tbl[7]  = '{1'b0, 4'b1111, 1'b1, 0,  4'b0001, 1, 1'b1, 0};
      tbl[8]  = '{1'b0, 4'b1111, 1'b1, 0,  4'b0010, 1, 1'b1, 100};
      tbl[9]  = '{1'b0, 4'b1111, 1'b1, 0,  4'b0100, 1, 1'b1, 200};
      tbl[10] = '{1'b0, 4'b1111, 1'b1, 0,  4'b1000, 1, 1'b1, 300};
      tbl[11] = '{1'b0, 4'b1111, 1'b1, 0,  4'b0001, 1, 1'b1, 0};
      tbl[12] = '{1'b0, 4'b1111, 1'b1, 0,  4'b0010, 1, 1'b1, 100};
      tbl[13] = '{1'b0, 4'b1111, 1'b1, 0,  4'b0100, 1, 1'b1, 200};
      tbl[14] = '{1'b0, 4'b1111, 1'b1, 0,  4'b1000, 1, 1'b1, 300};

      do_reset();
      chk("rst_valid", 32'(outValid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_ovf", 32'(overflowSeen), 32'd0);

      for (int i = 0; i < 15; i++) begin
         reset = tbl[i].rst; req = tbl[i].r; outReady = tbl[i].rdy; reqData = pack(tbl[i].base);
         @(posedge clock); #1;
         reset = 1'b0;
         chk("tbl_grant", 32'(grant), 32'(tbl[i].eg));
         chk("tbl_count", 32'(count), 32'(tbl[i].ec));
         chk("tbl_valid", 32'(outValid), 32'(tbl[i].ev));
         if (tbl[i].ev) chk("tbl_data", 32'(outData), 32'(tbl[i].ed));
         $display("vec %0d grant=%b count=%0d valid=%0d data=%0d", i, grant, count, outValid, outData);
      end

      // Fill to full with requester 1 and no consumer.
      do_reset();
      g1 = 0;
      for (k = 10; k < 30; k++) begin
         cyc(4'b0010, 1'b0, pack(k));
         if (grant[1]) g1++;
      end
      chk("full_grants", 32'(g1), 32'd8);
      chk("full_count", 32'(count), 32'd8);
      chk("full_ovf", 32'(overflowSeen), 32'd1);

      // Full with simultaneous pop: requester 2 gets in, occupancy stays at 8.
      exp_next = mq[1];
      cyc(4'b0100, 1'b1, pack(500));
      chk("fullpop_grant", 32'(grant), 32'b0100);
      chk("fullpop_count", 32'(count), 32'd8);
      chk("fullpop_head", 32'(outData), 32'(exp_next));
      cyc(4'b0100, 1'b0, pack(500));
      repeat (3) cyc(4'b0000, 1'b1, pack(0));
      chk("mid_count", 32'(count), 32'd5);

      // Reset mid-operation clears everything and restores requester 0 priority.
      do_reset();
      chk("midrst_count", 32'(count), 32'd0);
      chk("midrst_valid", 32'(outValid), 32'd0);
      chk("midrst_ovf", 32'(overflowSeen), 32'd0);
      cyc(4'b1111, 1'b0, pack(0));
      chk("midrst_grant", 32'(grant), 32'b0001);

      // Twenty words through the eight-deep buffer, pointers wrap twice.
      do_reset();
      popped.delete();
      for (int v = 1; v <= 20; v++) begin
         cyc(4'b0001, 1'b1, pack(v));
         cyc(4'b0001, 1'b1, pack(v));
      end
      repeat (3) cyc(4'b0000, 1'b1, pack(0));
      chk("wrap_len", 32'(popped.size()), 32'd20);
      for (int i = 0; i < popped.size() && i < 20; i++) chk("wrap_data", 32'(popped[i]), 32'(i + 1));

      // Random traffic with phases of light and heavy consumer back-pressure.
      do_reset();
      for (int ph = 0; ph < 6; ph++) begin
         repeat (80) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            rnd = {$urandom(), $urandom()};
            rr  = NREQ'($urandom());
            rdy = ($urandom_range(0, 5) < ph);
            cyc(rr, rdy, rnd[NREQ*W-1:0]);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
